// File: rtl/fixed_div_seq_pkg.sv
// Shared definitions for the sequential fixed-point divider: default
// Q-format, FSM state encoding and the result record.
package fixed_div_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BF    = 28;
  localparam int DEF_BI    = DEF_WIDTH - DEF_BF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } div_state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] q;
    logic                 div0;
    logic                 ovf;
  } div_res_t;

  // Number of quotient bits produced: integer/fraction bits plus one round bit.
  function automatic int iter_count(input int width, input int bf);
    return width + bf + 1;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational finishing stage of the divider: turns the raw unsigned
// quotient (with trailing round bit) into a signed, rounded, saturated
// Q-format word, and substitutes the divide-by-zero result.
module fixed_round_sat #(
  parameter int WIDTH = 32,
  parameter int BF    = 28,
  parameter int ROUND = 1
) (
  input  logic [WIDTH+BF:0] quot,
  input  logic              neg,
  input  logic              div0,
  input  logic              a_neg,
  output logic [WIDTH-1:0]  q,
  output logic              div0_o,
  output logic              ovf
);

  localparam int QW = WIDTH + BF + 1;
  localparam logic [QW-1:0]    LIM_POS = {{(QW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [QW-1:0]    LIM_NEG = LIM_POS + QW'(1);
  localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  logic          rnd_s;
  logic [QW-1:0] mag_s;

  // Round the magnitude, then apply sign with saturation at both rails.
  always_comb begin
    rnd_s  = (ROUND != 0) ? quot[0] : 1'b0;
    mag_s  = {1'b0, quot[QW-1:1]} + {{(QW-1){1'b0}}, rnd_s};
    q      = '0;
    div0_o = 1'b0;
    ovf    = 1'b0;
    if (div0) begin
      div0_o = 1'b1;
      q      = a_neg ? Q_MIN : Q_MAX;
    end else if (neg) begin
      if (mag_s > LIM_NEG) begin
        ovf = 1'b1;
        q   = Q_MIN;
      end else begin
        // mag == 2^(WIDTH-1) negates onto itself, giving the exact minimum.
        q = ~mag_s[WIDTH-1:0] + WIDTH'(1);
      end
    end else begin
      if (mag_s > LIM_POS) begin
        ovf = 1'b1;
        q   = Q_MAX;
      end else begin
        q = mag_s[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fixed_div_seq.sv
// Sequential signed fixed-point divider, one quotient bit per cycle using
// restoring radix-2 division on operand magnitudes. Operands are captured
// on acceptance, converted to magnitudes in SETUP, divided in DIV, then
// rounded/saturated in FIX and held in DONE until the consumer takes them.
module fixed_div_seq
  import fixed_div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BF    = DEF_BF,
  parameter int ROUND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_div0,
  output logic             out_ovf
);

  localparam int ITER = iter_count(WIDTH, BF);
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [ITER-1:0]  sr_q, sr_d;
  logic             neg_q, neg_d;
  logic             div0_q, div0_d;
  logic             a_neg_q, a_neg_d;
  logic [WIDTH-1:0] res_val_q, res_val_d;
  logic             res_div0_q, res_div0_d;
  logic             res_ovf_q, res_ovf_d;

  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH:0]   trial_s;
  logic             qbit_s;
  logic [WIDTH-1:0] rs_q_s;
  logic             rs_div0_s;
  logic             rs_ovf_s;

  // Operand magnitudes and the single trial subtraction of the divider.
  always_comb begin
    a_mag_s = op_a_q[WIDTH-1] ? (~op_a_q + WIDTH'(1)) : op_a_q;
    b_mag_s = op_b_q[WIDTH-1] ? (~op_b_q + WIDTH'(1)) : op_b_q;
    trial_s = {rem_q, sr_q[ITER-1]} - {1'b0, b_mag_q};
    qbit_s  = ~trial_s[WIDTH];
  end

  fixed_round_sat #(
    .WIDTH (WIDTH),
    .BF    (BF),
    .ROUND (ROUND)
  ) u_round_sat (
    .quot   (sr_q),
    .neg    (neg_q),
    .div0   (div0_q),
    .a_neg  (a_neg_q),
    .q      (rs_q_s),
    .div0_o (rs_div0_s),
    .ovf    (rs_ovf_s)
  );

  // Next-state and datapath update; flush overrides every handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    b_mag_d    = b_mag_q;
    rem_d      = rem_q;
    sr_d       = sr_q;
    neg_d      = neg_q;
    div0_d     = div0_q;
    a_neg_d    = a_neg_q;
    res_val_d  = res_val_q;
    res_div0_d = res_div0_q;
    res_ovf_d  = res_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        sr_d    = {a_mag_s, {(BF+1){1'b0}}};
        b_mag_d = b_mag_s;
        rem_d   = '0;
        cnt_d   = '0;
        neg_d   = op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1];
        a_neg_d = op_a_q[WIDTH-1];
        div0_d  = (op_b_q == '0);
        state_d = (op_b_q == '0) ? ST_FIX : ST_DIV;
      end
      ST_DIV: begin
        // Remainder stays below |b|, so the dropped top bit is always zero.
        rem_d = qbit_s ? trial_s[WIDTH-1:0] : {rem_q[WIDTH-2:0], sr_q[ITER-1]};
        sr_d  = {sr_q[ITER-2:0], qbit_s};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_DIV;
        end
      end
      ST_FIX: begin
        res_val_d  = rs_q_s;
        res_div0_d = rs_div0_s;
        res_ovf_d  = rs_ovf_s;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          res_val_d  = '0;
          res_div0_d = 1'b0;
          res_ovf_d  = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      res_val_d  = '0;
      res_div0_d = 1'b0;
      res_ovf_d  = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State, counter and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      b_mag_q    <= '0;
      rem_q      <= '0;
      sr_q       <= '0;
      neg_q      <= 1'b0;
      div0_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      res_val_q  <= '0;
      res_div0_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      b_mag_q    <= b_mag_d;
      rem_q      <= rem_d;
      sr_q       <= sr_d;
      neg_q      <= neg_d;
      div0_q     <= div0_d;
      a_neg_q    <= a_neg_d;
      res_val_q  <= res_val_d;
      res_div0_q <= res_div0_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_q     = res_val_q;
  assign out_div0  = res_div0_q;
  assign out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_fixed_div_seq.sv
// Scoreboard bench for fixed_div_seq: a rounding instance and a truncating
// instance run in lockstep on the same stimulus.
module tb_fixed_div_seq;
  import fixed_div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        in_ready, out_valid, out_div0, out_ovf;
  logic [31:0] out_q;
  logic        t_in_ready, t_out_valid, t_out_div0, t_out_ovf;
  logic [31:0] t_out_q;

  typedef struct {
    div_res_t    res;
    logic [31:0] q_trunc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  fixed_div_seq #(.WIDTH(32), .BF(28), .ROUND(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_q(out_q), .out_div0(out_div0), .out_ovf(out_ovf)
  );

  fixed_div_seq #(.WIDTH(32), .BF(28), .ROUND(0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(t_out_valid),
    .out_ready(out_ready), .out_q(t_out_q), .out_div0(t_out_div0), .out_ovf(t_out_ovf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer division of a*2^29 by b, then round/sign/saturate.
  function automatic div_res_t model(input logic [31:0] a, input logic [31:0] b, input bit rnd);
    div_res_t r;
    longint sa, sb_v;
    longint unsigned am, bm, qq, mag;
    r.q = 32'd0; r.div0 = 1'b0; r.ovf = 1'b0;
    if (b == 32'd0) begin
      r.div0 = 1'b1;
      r.q = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return r;
    end
    sa = longint'($signed(a));
    sb_v = longint'($signed(b));
    am = (sa < 0) ? longint'(-sa) : sa;
    bm = (sb_v < 0) ? longint'(-sb_v) : sb_v;
    qq = (am << 29) / bm;
    mag = (qq >> 1) + (rnd ? (qq & 64'd1) : 64'd0);
    if ((a[31] ^ b[31]) == 1'b0) begin
      if (mag > 64'h7FFF_FFFF) begin r.q = 32'h7FFF_FFFF; r.ovf = 1'b1; end
      else r.q = mag[31:0];
    end else begin
      if (mag > 64'h8000_0000) begin r.q = 32'h8000_0000; r.ovf = 1'b1; end
      else r.q = 32'(~mag + 64'd1);
    end
    return r;
  endfunction

  // Present one operand pair; called at posedge+1 with the DUT idle.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit push,
                      input div_res_t r, input logic [31:0] qt, input int lat);
    exp_t e;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e.res = r; e.q_trunc = qt; e.lat = lat;
      sb.push_back(e);
    end
  endtask

  // Wait for the result, compare with scoreboard, optionally stall, then take it.
  task automatic wait_result(input int hold);
    exp_t e;
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: result seen=%b with no expectation", out_valid);
      return;
    end
    e = sb.pop_front();
    if (out_valid !== 1'b1 || cyc != e.lat) begin
      errors++;
      $display("FAIL latency: out_valid=%b after %0d cycles required %0d", out_valid, cyc, e.lat);
    end
    checks++;
    if (out_q !== e.res.q || out_div0 !== e.res.div0 || out_ovf !== e.res.ovf) begin
      errors++;
      $display("FAIL result: q=%h div0=%b ovf=%b required q=%h div0=%b ovf=%b",
               out_q, out_div0, out_ovf, e.res.q, e.res.div0, e.res.ovf);
    end
    checks++;
    if (t_out_valid !== 1'b1 || t_out_q !== e.q_trunc) begin
      errors++;
      $display("FAIL trunc_result: valid=%b q=%h required 1 q=%h", t_out_valid, t_out_q, e.q_trunc);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_q !== e.res.q || out_div0 !== e.res.div0 ||
          out_ovf !== e.res.ovf || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%b q=%h div0=%b ovf=%b in_ready=%b required q=%h",
                 i, out_valid, out_q, out_div0, out_ovf, in_ready, e.res.q);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_div0 !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake: in_ready=%b out_valid=%b div0=%b ovf=%b required 1 0 0 0",
               in_ready, out_valid, out_div0, out_ovf);
    end
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] qt,
                         input logic d0, input logic ov, input int lat);
    div_res_t r;
    r.q = q; r.div0 = d0; r.ovf = ov;
    send(a, b, 1'b1, r, qt, lat);
    wait_result(0);
  endtask

  // Check that no result appears for a while and the block sits idle.
  task automatic expect_quiet(input string tag);
    bit seen = 1'b0;
    bit busy = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
      if (in_ready !== 1'b1) busy = 1'b1;
    end
    checks++;
    if (seen || busy) begin
      errors++;
      $display("FAIL %s_quiet: out_valid_seen=%b not_ready_seen=%b required 0 0", tag, seen, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_q !== 32'd0 || out_div0 !== 1'b0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b q=%h div0=%b ovf=%b in_ready=%b required 0 0 0 0 1",
               out_valid, out_q, out_div0, out_ovf, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    run_one(32'h1000_0000, 32'h2000_0000, 32'h0800_0000, 32'h0800_0000, 1'b0, 1'b0, 63);
  endtask

  task automatic test_rounding();
    run_one(32'h1000_0000, 32'h3000_0000, 32'h0555_5555, 32'h0555_5555, 1'b0, 1'b0, 63);
    run_one(32'h2000_0000, 32'h3000_0000, 32'h0AAA_AAAB, 32'h0AAA_AAAA, 1'b0, 1'b0, 63);
    run_one(32'hF000_0000, 32'h3000_0000, 32'hFAAA_AAAB, 32'hFAAA_AAAB, 1'b0, 1'b0, 63);
    run_one(32'hE000_0000, 32'h3000_0000, 32'hF555_5555, 32'hF555_5556, 1'b0, 1'b0, 63);
  endtask

  task automatic test_div0();
    run_one(32'h1000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    run_one(32'hF000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 2);
  endtask

  task automatic test_overflow();
    run_one(32'h7000_0000, 32'h0800_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 63);
    run_one(32'h8000_0000, 32'h1000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 63);
  endtask

  task automatic test_backpressure();
    div_res_t r;
    r.q = 32'h0555_5555; r.div0 = 1'b0; r.ovf = 1'b0;
    send(32'h1000_0000, 32'h3000_0000, 1'b1, r, 32'h0555_5555, 63);
    wait_result(10);
  endtask

  task automatic test_flush();
    div_res_t r;
    r = '0;
    send(32'h1000_0000, 32'h2000_0000, 1'b0, r, 32'd0, 0);
    repeat (21) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    expect_quiet("flush");
    test_basic();
  endtask

  task automatic test_reset_abort();
    div_res_t r;
    r = '0;
    send(32'h1000_0000, 32'h2000_0000, 1'b0, r, 32'd0, 0);
    repeat (31) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_q !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort_state: valid=%b in_ready=%b q=%h required 0 1 0", out_valid, in_ready, out_q);
    end
    #2;
    rst_n = 1'b1;
    expect_quiet("reset_abort");
    test_basic();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 24);
      if (b == 32'd0) b = 32'h0000_0001;
      send(a, b, 1'b1, model(a, b, 1'b1), model(a, b, 1'b0).q, 63);
    wait_result(0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_div0();
    test_overflow();
    test_backpressure();
    test_flush();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixed_div_seq.md
FIXED_DIV_SEQ -- requirements
Module: fixed_div_seq

Interface
REQ-001 Parameter WIDTH, default 32, total fixed-point word width in bits.
REQ-002 Parameter BF, default 28, fractional bits; integer bits BI = WIDTH - BF, sign included.
REQ-003 Parameter ROUND, default 1, 1 = round-half-away-from-zero, 0 = truncate toward zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 in_a  input  WIDTH  signed dividend, Q(BI.BF).
REQ-009 in_b  input  WIDTH  signed divisor, Q(BI.BF).
REQ-010 flush  input  1  synchronous abort of the operation in flight.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 out_q  output  WIDTH  signed quotient, Q(BI.BF).
REQ-014 out_div0  output  1  divisor was zero.
REQ-015 out_ovf  output  1  result saturated due to range overflow.

Function
REQ-016 out_q SHALL equal a*2^BF/b, rounded per ROUND and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-017 States SHALL be IDLE, SETUP, DIV, FIX, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; acceptance is in_valid & in_ready on a rising edge, IDLE->SETUP.
REQ-019 SETUP (1 cycle) SHALL register |a|, |b|, the result sign (sign(a) XOR sign(b)) and the b==0 flag; next state is FIX if b==0, else DIV.
REQ-020 DIV SHALL run restoring radix-2 division of the unsigned dividend |a|<<BF (WIDTH+BF bits), one quotient bit per cycle, for ITER = WIDTH+BF+1 cycles; the last bit is the round bit.
REQ-021 An iteration counter SHALL count 0..ITER-1; DIV->FIX on terminal count.
REQ-022 FIX (1 cycle): magnitude = quotient>>1, plus the round bit if ROUND=1; apply sign; saturate; FIX->DONE.
REQ-023 Overflow SHALL be declared when the positive magnitude exceeds 2^(WIDTH-1)-1 or the negative magnitude exceeds 2^(WIDTH-1).
REQ-024 b==0 SHALL yield out_q = 2^(WIDTH-1)-1 when a>=0 and -2^(WIDTH-1) when a<0, with out_div0=1 and out_ovf=0.
REQ-025 Normal-path latency SHALL be ITER+2 cycles from the acceptance edge to out_valid=1; the div0 path SHALL take 2 cycles.
REQ-026 In DONE, out_valid=1 and out_q/out_div0/out_ovf SHALL stay stable until out_valid & out_ready, then DONE->IDLE.
REQ-027 Acceptance of the next operation SHALL occur no earlier than the cycle after the result handshake; no overlap.
REQ-028 out_valid, out_div0 and out_ovf SHALL be 0 outside DONE.
REQ-029 flush=1 in any state SHALL force IDLE at the next edge and discard the result; flush takes priority over every handshake.
REQ-030 a = -2^(WIDTH-1) SHALL be handled exactly, with a WIDTH-bit unsigned magnitude.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, with out_valid=0, out_q=0, out_div0=0, out_ovf=0, counter=0 and all datapath registers=0.
REQ-032 Reset asserted during an operation SHALL abort it, with no result ever presented.
REQ-033 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge.

Structure
REQ-034 The shared definitions package SHALL hold the default format constants (WIDTH, BI, BF), the state enum and a packed result struct {q, div0, ovf}.
REQ-035 Round-and-saturate logic SHALL be a single combinational sub-module fixed_round_sat, parametrised by WIDTH, used in FIX.
REQ-036 No divider IP or `/` operator SHALL be used; one subtractor of WIDTH+1 bits is the datapath.

Verification (WIDTH=32, BF=28)
REQ-037 a=32'h10000000 (1.0), b=32'h20000000 (2.0) -> out_q=32'h08000000, flags 0, out_valid exactly 63 cycles after acceptance.
REQ-038 a=1.0, b=32'h30000000 (3.0): ROUND=1 -> 32'h05555555; a=32'h20000000 (2.0) -> 32'h0AAAAAAB with ROUND=1, 32'h0AAAAAAA with ROUND=0; a=-1.0 (32'hF0000000) -> 32'hFAAAAAAB.
REQ-039 a=1.0, b=0 -> 32'h7FFFFFFF, div0=1, 2-cycle latency; a=32'hF0000000, b=0 -> 32'h80000000, div0=1.
REQ-040 a=32'h70000000 (7.0), b=32'h08000000 (0.5) -> 32'h7FFFFFFF, ovf=1; a=32'h80000000, b=32'h10000000 -> 32'h80000000, ovf=0.
REQ-041 out_ready held 0 for 10 cycles in DONE -> out_q, flags and out_valid stable, in_ready=0; handshake -> in_ready=1 the next cycle.
REQ-042 flush at DIV cycle 20, then a separate run with rst_n pulsed low at DIV cycle 30 -> in each run out_valid never asserts, IDLE and in_ready=1 afterwards, and the next operation (1.0/2.0) returns 32'h08000000.
